// File: rtl/swb_pkg.sv
// Shared types and helpers for the sliding-window line buffer.
package swb_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_STREAM,
    ST_DRAIN
  } state_e;

  // Bit offset of window element (r,c); r=0 is the oldest row, c=0 the leftmost column.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned k, input int unsigned dw);
    return dw * (r * k + c);
  endfunction

endpackage

// File: rtl/swb_line_mem.sv
// One image row of pixel storage: single address, combinational read-before-write.
module swb_line_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 28
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

endmodule

// File: rtl/sliding_window_buffer.sv
// Raster pixel stream in, every valid KxK window out over valid/ready, frame_end per frame.
// Optional macro SWB_PERF_EN adds stall_cnt / win_cnt performance counters.
module sliding_window_buffer
  import swb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          pix_in,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [K*K*DATA_W-1:0]      win_data,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic                       frame_end
`ifdef SWB_PERF_EN
  ,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                win_cnt
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_WIN   = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_WIN   = RW'(K - 1);
  localparam logic [RW-1:0] ROW_FILLD = RW'(K - 2);

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_end_q, frame_end_d;
  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];

  logic              pix_acc, win_take, col_wrap;
  logic [DATA_W-1:0] lm_rd   [K-1];
  logic [DATA_W-1:0] lm_wr   [K-1];
  logic [DATA_W-1:0] new_col [K];

  // Line memories cascade upward: the bottom one takes pix_in, each older one takes its neighbour's popped value.
  for (genvar j = 0; j < K - 1; j++) begin : g_lm
    if (j == K - 2) begin : g_bottom
      assign lm_wr[j] = pix_in;
    end else begin : g_upper
      assign lm_wr[j] = lm_rd[j+1];
    end
    assign new_col[j] = lm_rd[j];

    swb_line_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W)
    ) u_lm (
      .clk   (clk),
      .we    (pix_acc),
      .addr  (col_q),
      .wdata (lm_wr[j]),
      .rdata (lm_rd[j])
    );
  end
  assign new_col[K-1] = pix_in;

  assign pix_ready = reset_n && !clear && (state_q != ST_DRAIN) && (!win_valid_q || win_ready);
  assign pix_acc   = pix_valid && pix_ready;
  assign win_take  = win_valid_q && win_ready && !clear;
  assign col_wrap  = (col_q == COL_LAST);
  assign win_valid = win_valid_q;
  assign frame_end = frame_end_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    frame_end_d = 1'b0;
    win_d       = win_q;

    if (pix_acc) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = new_col[r];
      end
      col_d = col_wrap ? '0 : col_q + 1'b1;
      if (col_wrap) row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end

    if (pix_acc && (row_q >= ROW_WIN) && (col_q >= COL_WIN)) win_valid_d = 1'b1;
    else if (win_take)                                        win_valid_d = 1'b0;

    case (state_q)
      ST_FILL:   if (pix_acc && (row_q == ROW_FILLD) && col_wrap) state_d = ST_STREAM;
      ST_STREAM: if (pix_acc && (row_q == ROW_LAST) && col_wrap)  state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (win_take) begin
          state_d     = ST_FILL;
          frame_end_d = 1'b1;
          col_d       = '0;
          row_d       = '0;
        end
      end
      default:   state_d = ST_FILL;
    endcase

    if (clear) begin
      state_d     = ST_FILL;
      col_d       = '0;
      row_d       = '0;
      win_valid_d = 1'b0;
      frame_end_d = 1'b0;
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) win_data[win_idx(r, c, K, DATA_W) +: DATA_W] = win_q[r][c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FILL;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      frame_end_q <= 1'b0;
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K; c++) win_q[r][c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      frame_end_q <= frame_end_d;
      win_q       <= win_d;
    end
  end

`ifdef SWB_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] win_cnt_q, win_cnt_d;

  // Counters clear one edge after frame_end so the totals stay readable during the pulse.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    win_cnt_d   = win_cnt_q;
    if (clear || frame_end_q) begin
      stall_cnt_d = '0;
      win_cnt_d   = '0;
    end else begin
      if (win_valid_q && !win_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (win_take) win_cnt_d = win_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      win_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      win_cnt_q   <= win_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign win_cnt   = win_cnt_q;
`endif

endmodule
